// File: rtl/core_pkg.sv
// Shared core definitions: register/data widths, special indices, writeback payload.
package core_pkg;

  localparam int unsigned REG_W        = 6;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned NUM_REGS     = 1 << REG_W;
  localparam int unsigned REG_ZERO     = 0;
  localparam int unsigned REG_LINK     = 31;
  localparam int unsigned FP_BANK_BASE = 32;
  localparam int unsigned NO_WRITE     = 0;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    reg_idx_t wreg;
    data_t    wdata;
  } wb_entry_t;

  // A destination index of 0 never writes.
  function automatic logic is_write(reg_idx_t r);
    return r != REG_W'(NO_WRITE);
  endfunction

endpackage

// File: rtl/wb_mem_fifo.sv
// Small FIFO holding memory writebacks until a register-file port is free.
module wb_mem_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  wb_entry_t              push_data,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  wb_entry_t     slots [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count < FULL_CNT);
  assign head    = slots[rd_ptr];
  assign empty   = (count == '0);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wb.sv
// Writeback stage: commits alu/br/mem results, bypasses operands, tracks pending writes.
module regfile_wb
  import core_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 2,
  parameter int unsigned CNT_W     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REG_W-1:0]  rs_addr,
  input  logic [REG_W-1:0]  rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_rd,
  output logic              iss_ready,
  input  logic [REG_W-1:0]  alu_wreg,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic [REG_W-1:0]  br_wreg,
  input  logic [DATA_W-1:0] br_wdata,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready
);

  localparam int unsigned      MCNT_W  = $clog2(MEM_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [MCNT_W-1:0] MEM_FULL = MCNT_W'(MEM_DEPTH);

  data_t             regs    [NUM_REGS];
  logic [CNT_W-1:0]  cnt     [NUM_REGS];
  logic [CNT_W-1:0]  cnt_nxt [NUM_REGS];
  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic [MCNT_W-1:0] mem_count;
  logic              mem_empty;
  logic              mem_push;
  logic              mem_drain;
  logic              mem_we;
  logic              alu_we;
  logic              br_we;
  logic              head_conflict;
  logic              iss_fire;

  assign alu_we = is_write(alu_wreg);
  assign br_we  = is_write(br_wreg);

  // Head waits if it would race an alu/br write to the same register, keeping order.
  assign head_conflict = is_write(head.wreg) &&
                         ((head.wreg == alu_wreg) || (head.wreg == br_wreg));
  assign mem_drain  = !mem_empty && !(alu_we && br_we) && !head_conflict;
  assign mem_we     = mem_drain && is_write(head.wreg);
  assign mem_ready  = (mem_count < MEM_FULL);
  assign mem_push   = mem_valid && mem_ready;
  assign push_entry = '{wreg: mem_wreg, wdata: mem_wdata};

  // Hazard check uses only registered counters; same-cycle completions release next cycle.
  assign iss_ready = (cnt[rs_addr] == '0) && (cnt[rt_addr] == '0) && (cnt[iss_rd] != CNT_MAX);
  assign iss_fire  = iss_valid && iss_ready && is_write(iss_rd);

  wb_mem_fifo #(
    .DEPTH(MEM_DEPTH)
  ) u_mem_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (mem_push),
    .push_data(push_entry),
    .pop      (mem_drain),
    .head     (head),
    .count    (mem_count),
    .empty    (mem_empty)
  );

  // Operand bypass: br, then alu, then draining mem head, then array.
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (!rstn || rs_addr == REG_W'(REG_ZERO)) rs_data = '0;
    else if (br_we && br_wreg == rs_addr)     rs_data = br_wdata;
    else if (alu_we && alu_wreg == rs_addr)   rs_data = alu_wdata;
    else if (mem_we && head.wreg == rs_addr)  rs_data = head.wdata;
    if (!rstn || rt_addr == REG_W'(REG_ZERO)) rt_data = '0;
    else if (br_we && br_wreg == rt_addr)     rt_data = br_wdata;
    else if (alu_we && alu_wreg == rt_addr)   rt_data = alu_wdata;
    else if (mem_we && head.wreg == rt_addr)  rt_data = head.wdata;
  end

  // Net scoreboard change per register: one reservation in, up to three completions out.
  always_comb begin
    int net;
    net = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      net = int'(cnt[i]);
      if (iss_fire && iss_rd == REG_W'(i))    net = net + 1;
      if (alu_we && alu_wreg == REG_W'(i))    net = net - 1;
      if (br_we && br_wreg == REG_W'(i))      net = net - 1;
      if (mem_we && head.wreg == REG_W'(i))   net = net - 1;
      if (net < 0)                net = 0;
      if (net > int'(CNT_MAX))    net = int'(CNT_MAX);
      cnt_nxt[i] = CNT_W'(net);
    end
  end

  // Pending counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Register array; br is written after alu so br wins a same-register collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (alu_we) regs[alu_wreg]  <= alu_wdata;
      if (br_we)  regs[br_wreg]   <= br_wdata;
      if (mem_we) regs[head.wreg] <= head.wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_wb;

  localparam int CMAX   = 3;
  localparam int MDEPTH = 2;

  logic        clk;
  logic        rstn;
  logic [5:0]  rs_addr, rt_addr, iss_rd, alu_wreg, br_wreg, mem_wreg;
  logic [31:0] rs_data, rt_data, alu_wdata, br_wdata, mem_wdata;
  logic        iss_valid, iss_ready, mem_valid, mem_ready;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [5:0]  w;
    logic [31:0] d;
  } ent_t;

  logic [31:0] m_regs [64];
  int          m_cnt  [64];
  ent_t        m_fifo [$];
  ent_t        e_head;
  logic        e_drain, e_iss_ready, e_mem_ready;
  logic [31:0] e_rs, e_rt;

  regfile_wb #(.MEM_DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rstn(rstn),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .alu_wreg(alu_wreg), .alu_wdata(alu_wdata),
    .br_wreg(br_wreg), .br_wdata(br_wdata),
    .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_regs[i] = 32'h0;
      m_cnt[i]  = 0;
    end
    m_fifo.delete();
  endfunction

  function automatic logic [31:0] m_read(logic [5:0] a);
    if (a == 6'd0) return 32'h0;
    if (br_wreg != 6'd0 && br_wreg == a) return br_wdata;
    if (alu_wreg != 6'd0 && alu_wreg == a) return alu_wdata;
    if (e_drain && e_head.w == a) return e_head.d;
    return m_regs[a];
  endfunction

  function automatic void model_eval();
    e_mem_ready = (m_fifo.size() < MDEPTH);
    e_iss_ready = (m_cnt[rs_addr] == 0) && (m_cnt[rt_addr] == 0) && (m_cnt[iss_rd] != CMAX);
    e_drain = 1'b0;
    e_head  = '{w: 6'd0, d: 32'h0};
    if (m_fifo.size() > 0) begin
      e_head  = m_fifo[0];
      e_drain = (alu_wreg == 6'd0 || br_wreg == 6'd0) &&
                !(e_head.w != 6'd0 && (e_head.w == alu_wreg || e_head.w == br_wreg));
    end
    e_rs = m_read(rs_addr);
    e_rt = m_read(rt_addr);
  endfunction

  function automatic void model_commit();
    int delta [64];
    for (int i = 0; i < 64; i++) delta[i] = 0;
    if (alu_wreg != 6'd0) begin m_regs[alu_wreg] = alu_wdata; delta[alu_wreg]--; end
    if (br_wreg != 6'd0)  begin m_regs[br_wreg]  = br_wdata;  delta[br_wreg]--;  end
    if (e_drain && e_head.w != 6'd0) begin m_regs[e_head.w] = e_head.d; delta[e_head.w]--; end
    if (iss_valid && e_iss_ready && iss_rd != 6'd0) delta[iss_rd]++;
    for (int i = 1; i < 64; i++) begin
      m_cnt[i] = m_cnt[i] + delta[i];
      if (m_cnt[i] < 0) m_cnt[i] = 0;
      if (m_cnt[i] > CMAX) m_cnt[i] = CMAX;
    end
    if (e_drain) void'(m_fifo.pop_front());
    if (mem_valid && e_mem_ready) m_fifo.push_back('{w: mem_wreg, d: mem_wdata});
  endfunction

  task automatic cycle();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    rs_addr = 6'd0; rt_addr = 6'd0; iss_valid = 1'b0; iss_rd = 6'd0;
    alu_wreg = 6'd0; alu_wdata = 32'h0; br_wreg = 6'd0; br_wdata = 32'h0;
    mem_valid = 1'b0; mem_wreg = 6'd0; mem_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    model_reset();
    rs_addr = 6'd5; rt_addr = 6'd63;
    #1;
    n_checks++; if (rs_data !== 32'h0) $display("FAIL reset_r5: got %h want 0", rs_data); else n_pass++;
    n_checks++; if (rt_data !== 32'h0) $display("FAIL reset_r63: got %h want 0", rt_data); else n_pass++;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready: got %b want 1", iss_ready); else n_pass++;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL reset_mem_ready: got %b want 1", mem_ready); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset_midstream();
    idle();
    alu_wreg = 6'd1; alu_wdata = 32'h11; br_wreg = 6'd31; br_wdata = 32'h22;
    mem_valid = 1'b1; mem_wreg = 6'd8; mem_wdata = 32'hA;
    cycle();
    mem_wreg = 6'd9; mem_wdata = 32'hB;
    cycle();
    mem_valid = 1'b0;
    #1;
    n_checks++; if (mem_ready !== 1'b0) $display("FAIL mid_full: got %b want 0", mem_ready); else n_pass++;
    rstn = 1'b0;
    model_reset();
    rs_addr = 6'd1;
    #1;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL mid_rst_mem_ready: got %b want 1", mem_ready); else n_pass++;
    n_checks++; if (rs_data !== 32'h0) $display("FAIL mid_rst_rs: got %h want 0", rs_data); else n_pass++;
    @(negedge clk);
    idle();
    rstn = 1'b1;
    rs_addr = 6'd8; rt_addr = 6'd1;
    cycle();
    n_checks++; if (rs_data !== 32'h0) $display("FAIL mid_r8: got %h want 0", rs_data); else n_pass++;
    n_checks++; if (rt_data !== 32'h0) $display("FAIL mid_r1: got %h want 0", rt_data); else n_pass++;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL mid_empty: got %b want 1", mem_ready); else n_pass++;
  endtask

  task automatic test_alu_write();
    idle();
    alu_wreg = 6'd5; alu_wdata = 32'h0000_1234; rs_addr = 6'd5;
    #1;
    n_checks++; if (rs_data !== 32'h1234) $display("FAIL alu_bypass: got %h want 1234", rs_data); else n_pass++;
    cycle();
    alu_wreg = 6'd0; alu_wdata = 32'hFFFF;
    #1;
    n_checks++; if (rs_data !== 32'h1234) $display("FAIL alu_array: got %h want 1234", rs_data); else n_pass++;
    rt_addr = 6'd0;
    cycle();
    n_checks++; if (rs_data !== 32'h1234) $display("FAIL alu_zero_nochange: got %h want 1234", rs_data); else n_pass++;
    n_checks++; if (rt_data !== 32'h0) $display("FAIL r0_reads_zero: got %h want 0", rt_data); else n_pass++;
  endtask

  task automatic test_collision();
    idle();
    iss_valid = 1'b1; iss_rd = 6'd31;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (iss_ready !== 1'b1) $display("FAIL coll_issue%0d: got %b want 1", k, iss_ready); else n_pass++;
      cycle();
    end
    idle();
    rs_addr = 6'd31;
    br_wreg = 6'd31; br_wdata = 32'h0101; alu_wreg = 6'd31; alu_wdata = 32'hBEEF;
    #1;
    n_checks++; if (rs_data !== 32'h0101) $display("FAIL coll_bypass: got %h want 0101", rs_data); else n_pass++;
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL coll_pending: got %b want 0", iss_ready); else n_pass++;
    cycle();
    br_wreg = 6'd0; alu_wreg = 6'd0;
    #1;
    n_checks++; if (rs_data !== 32'h0101) $display("FAIL coll_r31: got %h want 0101", rs_data); else n_pass++;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL coll_released: got %b want 1", iss_ready); else n_pass++;
  endtask

  task automatic test_mem_order();
    idle();
    alu_wreg = 6'd1; alu_wdata = 32'h1; br_wreg = 6'd31; br_wdata = 32'h31;
    mem_valid = 1'b1; mem_wreg = 6'd8; mem_wdata = 32'hA;
    cycle();
    mem_wreg = 6'd9; mem_wdata = 32'hB;
    cycle();
    mem_valid = 1'b0; rs_addr = 6'd8; rt_addr = 6'd9;
    cycle();
    cycle();
    n_checks++; if (mem_ready !== 1'b0) $display("FAIL mem_held_full: got %b want 0", mem_ready); else n_pass++;
    n_checks++; if (rs_data !== 32'h0) $display("FAIL mem_no_drain: got %h want 0", rs_data); else n_pass++;
    alu_wreg = 6'd0; br_wreg = 6'd0;
    #1;
    n_checks++; if (rs_data !== 32'hA) $display("FAIL mem_r8_bypass: got %h want a", rs_data); else n_pass++;
    n_checks++; if (rt_data !== 32'h0) $display("FAIL mem_r9_early: got %h want 0", rt_data); else n_pass++;
    cycle();
    n_checks++; if (rt_data !== 32'hB) $display("FAIL mem_r9_bypass: got %h want b", rt_data); else n_pass++;
    cycle();
    n_checks++; if (rs_data !== 32'hA) $display("FAIL mem_r8: got %h want a", rs_data); else n_pass++;
    n_checks++; if (rt_data !== 32'hB) $display("FAIL mem_r9: got %h want b", rt_data); else n_pass++;
    n_checks++; if (mem_ready !== 1'b1) $display("FAIL mem_ready_back: got %b want 1", mem_ready); else n_pass++;
    rs_addr = 6'd4; rt_addr = 6'd0;
    alu_wreg = 6'd4; alu_wdata = 32'h44; mem_valid = 1'b1; mem_wreg = 6'd4; mem_wdata = 32'hC4;
    cycle();
    mem_valid = 1'b0; alu_wdata = 32'h45;
    #1;
    n_checks++; if (rs_data !== 32'h45) $display("FAIL r4_alu_wins: got %h want 45", rs_data); else n_pass++;
    cycle();
    alu_wreg = 6'd0;
    #1;
    n_checks++; if (rs_data !== 32'hC4) $display("FAIL r4_mem_bypass: got %h want c4", rs_data); else n_pass++;
    cycle();
    n_checks++; if (rs_data !== 32'hC4) $display("FAIL r4_final: got %h want c4", rs_data); else n_pass++;
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1'b1; iss_rd = 6'd7;
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL sb_issue7: got %b want 1", iss_ready); else n_pass++;
    cycle();
    iss_rd = 6'd0; rs_addr = 6'd7;
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL sb_rs7_hazard: got %b want 0", iss_ready); else n_pass++;
    cycle();
    alu_wreg = 6'd7; alu_wdata = 32'h77;
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL sb_same_cycle: got %b want 0", iss_ready); else n_pass++;
    cycle();
    alu_wreg = 6'd0;
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL sb_next_cycle: got %b want 1", iss_ready); else n_pass++;
    cycle();
    rs_addr = 6'd0; iss_rd = 6'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (iss_ready !== 1'b1) $display("FAIL sb_rd3_issue%0d: got %b want 1", k, iss_ready); else n_pass++;
      cycle();
    end
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL sb_rd3_full: got %b want 0", iss_ready); else n_pass++;
    iss_valid = 1'b0; alu_wreg = 6'd3;
    cycle();
    iss_valid = 1'b1;
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL sb_rd3_one_free: got %b want 1", iss_ready); else n_pass++;
    cycle();
    alu_wreg = 6'd0;
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL sb_rd3_net_zero: got %b want 1", iss_ready); else n_pass++;
    cycle();
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL sb_rd3_refull: got %b want 0", iss_ready); else n_pass++;
    iss_valid = 1'b0; iss_rd = 6'd0; alu_wreg = 6'd3;
    cycle(); cycle(); cycle();
    alu_wreg = 6'd0; rs_addr = 6'd3;
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL sb_rd3_drained: got %b want 1", iss_ready); else n_pass++;
  endtask

  function automatic logic [5:0] rnd_reg();
    if ($urandom_range(0, 4) == 0) return 6'($urandom_range(32, 63));
    return 6'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rs_addr   = rnd_reg();
      rt_addr   = rnd_reg();
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = rnd_reg();
      alu_wreg  = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 7));
      alu_wdata = $urandom;
      br_wreg   = ($urandom_range(0, 2) == 0) ? 6'd31 : 6'd0;
      br_wdata  = $urandom;
      mem_valid = 1'($urandom_range(0, 1));
      mem_wreg  = rnd_reg();
      mem_wdata = $urandom;
      #1;
      model_eval();
      n_checks++; if (rs_data !== e_rs) $display("FAIL rnd_rs[%0d]: got %h want %h", n, rs_data, e_rs); else n_pass++;
      n_checks++; if (rt_data !== e_rt) $display("FAIL rnd_rt[%0d]: got %h want %h", n, rt_data, e_rt); else n_pass++;
      n_checks++; if (iss_ready !== e_iss_ready) $display("FAIL rnd_iss_ready[%0d]: got %b want %b", n, iss_ready, e_iss_ready); else n_pass++;
      n_checks++; if (mem_ready !== e_mem_ready) $display("FAIL rnd_mem_ready[%0d]: got %b want %b", n, mem_ready, e_mem_ready); else n_pass++;
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_alu_write();
    test_collision();
    test_mem_order();
    test_scoreboard();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
